// File: rtl/fp_rf_pkg.sv
// Shared types and constants for the floating-point register file.
//   fflags_t : sticky exception flags {nv, dz, of, uf, nx}
//   frm_t    : rounding-mode encodings (5 and 6 are reserved)
//   fflags_accum() : merges newly raised flags into a flag base
package fp_rf_pkg;

  localparam int FFLAGS_W = 5;
  localparam int FRM_W    = 3;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  typedef enum logic [FRM_W-1:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4,
    DYN = 3'd7
  } frm_t;

  // Sticky accumulation: raised flags are ORed on top of the base.
  function automatic fflags_t fflags_accum(fflags_t base, logic en,
                                           logic [FFLAGS_W-1:0] raised);
    return fflags_t'(base | (en ? raised : {FFLAGS_W{1'b0}}));
  endfunction

endpackage

// File: rtl/fp_scoreboard.sv
// Per-register busy scoreboard for multi-cycle FPU operations.
// An accepted issue marks its destination busy; an FPU writeback clears it.
// Ports:
//   clk, n_rst           clock, asynchronous active-low reset
//   rd_addr              packed read addresses (sources of the issuing op)
//   issue_valid/_rd/_src_mask  issuing op, its destination, true sources
//   issue_ready          op may issue (destination and masked sources idle)
//   fpu_wb_valid/_rd     FPU writeback clearing a busy bit
//   ld_rd, ld_ready      load destination and its acceptance
//   busy_vec             registered busy bits
// FP_BYPASS_EN: a source being cleared by this cycle's writeback counts
// as ready for issue.
module fp_scoreboard
  import fp_rf_pkg::*;
#(
  parameter int NUM_REGS     = 32,
  parameter int NUM_RD_PORTS = 3,
  parameter int AW           = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic [NUM_RD_PORTS*AW-1:0] rd_addr,
  input  logic                       issue_valid,
  input  logic [AW-1:0]              issue_rd,
  input  logic [NUM_RD_PORTS-1:0]    issue_src_mask,
  output logic                       issue_ready,
  input  logic                       fpu_wb_valid,
  input  logic [AW-1:0]              fpu_wb_rd,
  input  logic [AW-1:0]              ld_rd,
  output logic                       ld_ready,
  output logic [NUM_REGS-1:0]        busy_vec
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [NUM_REGS-1:0] clr_vec_s, set_vec_s, src_busy_s;

  // Busy next-state; a same-rd issue and writeback lets the set win.
  always_comb begin
    clr_vec_s            = '0;
    clr_vec_s[fpu_wb_rd] = fpu_wb_valid;
    set_vec_s            = '0;
    set_vec_s[issue_rd]  = issue_valid & issue_ready;
    busy_d               = (busy_q & ~clr_vec_s) | set_vec_s;
  end

  // Busy view used for source operands of the issuing op.
  always_comb begin
`ifdef FP_BYPASS_EN
    src_busy_s = busy_q & ~clr_vec_s;
`else
    src_busy_s = busy_q;
`endif
  end

  // Issue and load acceptance; the destination check uses registered busy only.
  always_comb begin
    issue_ready = ~busy_q[issue_rd];
    for (int i = 0; i < NUM_RD_PORTS; i++) begin
      issue_ready = issue_ready &
                    ~(issue_src_mask[i] & src_busy_s[rd_addr[i*AW +: AW]]);
    end
    ld_ready = ~fpu_wb_valid & ~busy_q[ld_rd];
  end

  // Busy register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/fp_scoreboard_chk.sv
// Checker: an accepted issue and an FPU writeback must never target the
// same destination in one cycle (the scoreboard lets the set win if so).
// Ports: clk, n_rst, issue handshake, writeback valid and destinations.
module fp_scoreboard_chk #(
  parameter int AW = 5
) (
  input logic          clk,
  input logic          n_rst,
  input logic          issue_valid,
  input logic          issue_ready,
  input logic [AW-1:0] issue_rd,
  input logic          fpu_wb_valid,
  input logic [AW-1:0] fpu_wb_rd
);

  // Flags a same-cycle issue/writeback collision on one destination.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      assert (!(issue_valid && issue_ready && fpu_wb_valid && (issue_rd == fpu_wb_rd)))
        else $error("issue/writeback collision on rd %0d", issue_rd);
    end
  end

endmodule

// File: rtl/fp_regfile_scoreboard.sv
// Parametrised FP register file with N combinational read ports, arbitrated
// FPU-writeback / load write path, busy scoreboard and a local fcsr.
// Ports:
//   clk, n_rst                  clock, asynchronous active-low reset
//   rd_addr / rd_data           packed read ports (port i at i*AW / i*DATA_W)
//   issue_valid/_rd/_src_mask, issue_ready   issue handshake
//   fpu_wb_valid/_rd/_data/_flags            FPU writeback (never stalled)
//   ld_valid/_rd/_data, ld_ready             load write (yields to writeback)
//   csr_we, csr_wdata {frm, fflags}, frm, fflags   fcsr
//   busy_vec                    scoreboard state
// Optional macro FP_BYPASS_EN: reads and issue_ready see this cycle's write.
module fp_regfile_scoreboard
  import fp_rf_pkg::*;
#(
  parameter  int NUM_REGS     = 32,
  parameter  int DATA_W       = 32,
  parameter  int NUM_RD_PORTS = 3,
  localparam int AW           = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic [NUM_RD_PORTS*AW-1:0]     rd_addr,
  output logic [NUM_RD_PORTS*DATA_W-1:0] rd_data,
  input  logic                           issue_valid,
  input  logic [AW-1:0]                  issue_rd,
  input  logic [NUM_RD_PORTS-1:0]        issue_src_mask,
  output logic                           issue_ready,
  input  logic                           fpu_wb_valid,
  input  logic [AW-1:0]                  fpu_wb_rd,
  input  logic [DATA_W-1:0]              fpu_wb_data,
  input  logic [FFLAGS_W-1:0]            fpu_wb_flags,
  input  logic                           ld_valid,
  input  logic [AW-1:0]                  ld_rd,
  input  logic [DATA_W-1:0]              ld_data,
  output logic                           ld_ready,
  input  logic                           csr_we,
  input  logic [7:0]                     csr_wdata,
  output logic [FRM_W-1:0]               frm,
  output logic [FFLAGS_W-1:0]            fflags,
  output logic [NUM_REGS-1:0]            busy_vec
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  fflags_t           fflags_q, fflags_d, flag_base_s;
  logic [FRM_W-1:0]  frm_q, frm_d;
  logic              ld_ready_s, ld_acc_s, wr_en_s;
  logic [AW-1:0]     wr_addr_s;
  logic [DATA_W-1:0] wr_data_s;

  fp_scoreboard #(
    .NUM_REGS     (NUM_REGS),
    .NUM_RD_PORTS (NUM_RD_PORTS),
    .AW           (AW)
  ) u_sb (
    .clk            (clk),
    .n_rst          (n_rst),
    .rd_addr        (rd_addr),
    .issue_valid    (issue_valid),
    .issue_rd       (issue_rd),
    .issue_src_mask (issue_src_mask),
    .issue_ready    (issue_ready),
    .fpu_wb_valid   (fpu_wb_valid),
    .fpu_wb_rd      (fpu_wb_rd),
    .ld_rd          (ld_rd),
    .ld_ready       (ld_ready_s),
    .busy_vec       (busy_vec)
  );

  assign ld_ready = ld_ready_s;

  // Single write port: FPU writeback first, an accepted load otherwise.
  always_comb begin
    ld_acc_s  = ld_valid & ld_ready_s;
    wr_en_s   = fpu_wb_valid | ld_acc_s;
    wr_addr_s = fpu_wb_valid ? fpu_wb_rd : ld_rd;
    wr_data_s = fpu_wb_valid ? fpu_wb_data : ld_data;
    for (int r = 0; r < NUM_REGS; r++) begin
      regs_d[r] = (wr_en_s && (wr_addr_s == AW'(r))) ? wr_data_s : regs_q[r];
    end
  end

  // fcsr next-state: a CSR write sets the base, writeback flags still accrue.
  always_comb begin
    flag_base_s = csr_we ? fflags_t'(csr_wdata[FFLAGS_W-1:0]) : fflags_q;
    fflags_d    = fflags_accum(flag_base_s, fpu_wb_valid, fpu_wb_flags);
    frm_d       = csr_we ? csr_wdata[FFLAGS_W +: FRM_W] : frm_q;
  end

  // Combinational read ports.
  always_comb begin
    rd_data = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
`ifdef FP_BYPASS_EN
      rd_data[p*DATA_W +: DATA_W] =
        (fpu_wb_valid && (rd_addr[p*AW +: AW] == fpu_wb_rd)) ? fpu_wb_data :
        (ld_acc_s && (rd_addr[p*AW +: AW] == ld_rd))         ? ld_data     :
        regs_q[rd_addr[p*AW +: AW]];
`else
      rd_data[p*DATA_W +: DATA_W] = regs_q[rd_addr[p*AW +: AW]];
`endif
    end
  end

  // Register array and fcsr state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
      fflags_q <= '0;
      frm_q    <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
      fflags_q <= fflags_d;
      frm_q    <= frm_d;
    end
  end

  assign fflags = fflags_q;
  assign frm    = frm_q;

endmodule
